// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU controller:
// opcodes, sequencer phases and the control-pin bundle.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ld_ac;
    logic data_e;
    logic halt;
  } ctrl_t;

  function automatic logic is_aluop(opcode_e op);
    return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath bundle: IR opcode and zero flag in,
// memory / PC / accumulator control pins out.
interface cpu_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       wr;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       ld_ac;
  logic       data_e;
  logic       halt;

  modport master (
    input  opcode, zero,
    output sel, rd, wr, ld_ir,
    output inc_pc, ld_pc, ld_ac,
    output data_e, halt
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, wr, ld_ir,
    input  inc_pc, ld_pc, ld_ac,
    input  data_e, halt
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational control decode of (phase, opcode, zero, halted).
module ctrl_decode
  import cpu_pkg::*;
(
  input  phase_e  phase,
  input  opcode_e opcode,
  input  logic    zero,
  input  logic    halted,
  output ctrl_t   ctrl
);

  logic alu;
  logic sto;
  logic jmp;
  logic skz;

  assign alu = is_aluop(opcode);
  assign sto = (opcode == OP_STO);
  assign jmp = (opcode == OP_JMP);
  assign skz = (opcode == OP_SKZ);

  always_comb begin
    ctrl = '0;
    if (halted) begin
      ctrl.halt = 1'b1;
    end else begin
      unique case (phase)
        INST_ADDR: ctrl.sel = 1'b1;
        INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          ctrl.inc_pc = 1'b1;
          ctrl.halt   = (opcode == OP_HLT);
        end
        OP_FETCH: begin
          ctrl.sel = alu;
          ctrl.rd  = alu;
        end
        ALU_OP: begin
          ctrl.sel    = alu;
          ctrl.rd     = alu;
          ctrl.inc_pc = skz & zero;
          ctrl.ld_pc  = jmp;
          ctrl.data_e = sto;
        end
        STORE: begin
          ctrl.sel    = alu | sto;
          ctrl.rd     = alu;
          ctrl.wr     = sto;
          ctrl.ld_ac  = alu;
          ctrl.ld_pc  = jmp;
          ctrl.inc_pc = jmp;
          ctrl.data_e = sto;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer; optional single-step hold
// after each instruction under CPU_CTRL_SINGLE_STEP_EN.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic             step,
  output logic             step_wait,
`endif
  cpu_controller_if.master bus,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_cnt
);

  phase_e ph, ph_n;
  logic   halted, halted_n;
  logic   hold, hold_n;
  logic   run;
  logic   step_rise;
  logic [CNT_W-1:0] cnt_n;
  ctrl_t  dec, ctl;

`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam logic STEP_EN = 1'b1;
  logic step_q;

  always_ff @(posedge clk or negedge rst)
    if (!rst) step_q <= 1'b0;
    else      step_q <= step;

  assign step_rise = step & ~step_q;
  assign step_wait = hold;
`else
  localparam logic STEP_EN = 1'b0;
  assign step_rise = 1'b0;
`endif

  always_comb begin
    ph_n     = ph;
    halted_n = halted;
    hold_n   = hold;
    cnt_n    = instr_cnt;
    if (halted) begin
      ph_n = ph;
    end else if (ph == OP_ADDR && bus.opcode == OP_HLT) begin
      halted_n = 1'b1;
    end else if (hold) begin
      if (step_rise) hold_n = 1'b0;
    end else begin
      ph_n = phase_e'(ph + 3'd1);
      if (ph == STORE) begin
        cnt_n  = instr_cnt + CNT_W'(1);
        hold_n = STEP_EN;
      end
    end
  end

  // run stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph        <= INST_ADDR;
      halted    <= 1'b0;
      hold      <= 1'b0;
      run       <= 1'b0;
      instr_cnt <= '0;
    end else begin
      ph        <= ph_n;
      halted    <= halted_n;
      hold      <= hold_n;
      run       <= 1'b1;
      instr_cnt <= cnt_n;
    end
  end

  ctrl_decode u_dec (
    .phase  (ph),
    .opcode (opcode_e'(bus.opcode)),
    .zero   (bus.zero),
    .halted (halted),
    .ctrl   (dec)
  );

  assign ctl = (rst && run && !hold) ? dec : '0;

  assign bus.sel    = ctl.sel;
  assign bus.rd     = ctl.rd;
  assign bus.wr     = ctl.wr;
  assign bus.ld_ir  = ctl.ld_ir;
  assign bus.inc_pc = ctl.inc_pc;
  assign bus.ld_pc  = ctl.ld_pc;
  assign bus.ld_ac  = ctl.ld_ac;
  assign bus.data_e = ctl.data_e;
  assign bus.halt   = ctl.halt;
  assign phase      = ph;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller (CNT_W=2 to exercise wrap).
module tb_cpu_controller;

  localparam logic [8:0] SEL  = 9'h100;
  localparam logic [8:0] RD   = 9'h080;
  localparam logic [8:0] WR   = 9'h040;
  localparam logic [8:0] LDIR = 9'h020;
  localparam logic [8:0] INC  = 9'h010;
  localparam logic [8:0] LDPC = 9'h008;
  localparam logic [8:0] LDAC = 9'h004;
  localparam logic [8:0] DE   = 9'h002;
  localparam logic [8:0] HLT  = 9'h001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] phase;
  logic [1:0] instr_cnt;
  logic [8:0] ctl;
  int         checks = 0;
  int         errors = 0;

`ifdef CPU_CTRL_SINGLE_STEP_EN
  logic step = 1'b0;
  logic step_wait;
`endif

  always #5 clk = ~clk;

  cpu_controller_if bus ();

  cpu_controller #(.CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step      (step),
    .step_wait (step_wait),
`endif
    .bus       (bus.master),
    .phase     (phase),
    .instr_cnt (instr_cnt)
  );

  assign ctl = {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.inc_pc,
                bus.ld_pc, bus.ld_ac, bus.data_e, bus.halt};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic run_instr(input string nm, input logic [2:0] op,
                           input logic z, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7,
                           input int start, input logic [1:0] cnt_exp);
    logic [8:0] e [8];
    e[0] = SEL;
    e[1] = SEL | RD;
    e[2] = SEL | RD | LDIR;
    e[3] = SEL | RD | LDIR;
    e[4] = INC;
    e[5] = e5;
    e[6] = e6;
    e[7] = e7;
    bus.opcode = op;
    bus.zero   = z;
    for (int p = start; p < 8; p++) begin
      check($sformatf("%s phase@%0d", nm, p), 32'(phase), p);
      check($sformatf("%s ctl@%0d", nm, p), 32'(ctl), 32'(e[p]));
      tick();
    end
    check($sformatf("%s cnt", nm), 32'(instr_cnt), 32'(cnt_exp));
`ifdef CPU_CTRL_SINGLE_STEP_EN
    check($sformatf("%s step_wait", nm), 32'(step_wait), 1);
    check($sformatf("%s hold ctl", nm), 32'(ctl), 0);
    step = 1'b1;
    tick();
    step = 1'b0;
`endif
  endtask

  initial begin
    rst        = 1'b0;
    bus.opcode = 3'd5;
    bus.zero   = 1'b0;
    tick();
    tick();
    check("rst phase", 32'(phase), 0);
    check("rst ctl", 32'(ctl), 0);
    check("rst cnt", 32'(instr_cnt), 0);

    rst = 1'b1;
    #1;
    check("first pass ctl", 32'(ctl), 0);
    tick();

    run_instr("LDA", 3'd5, 1'b0, SEL | RD, SEL | RD,
              SEL | RD | LDAC, 1, 2'd1);
    run_instr("STO", 3'd6, 1'b0, 9'h0, DE,
              SEL | WR | DE, 0, 2'd2);
    run_instr("SKZ1", 3'd1, 1'b1, 9'h0, INC, 9'h0, 0, 2'd3);
    run_instr("SKZ0", 3'd1, 1'b0, 9'h0, 9'h0, 9'h0, 0, 2'd0);
    run_instr("JMP", 3'd7, 1'b0, 9'h0, LDPC,
              LDPC | INC, 0, 2'd1);

    bus.opcode = 3'd0;
    for (int p = 0; p < 4; p++) tick();
    check("hlt phase", 32'(phase), 4);
    check("hlt entry ctl", 32'(ctl), 32'(INC | HLT));
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hlt stuck phase", 32'(phase), 4);
      check("hlt stuck ctl", 32'(ctl), 32'(HLT));
    end
    check("hlt cnt", 32'(instr_cnt), 1);

    #1;
    rst = 1'b0;
    #1;
    check("async rst phase", 32'(phase), 0);
    check("async rst ctl", 32'(ctl), 0);
    check("async rst cnt", 32'(instr_cnt), 0);
    #2;
    rst = 1'b1;
    tick();

    bus.opcode = 3'd6;
    for (int i = 0; i < 20 && phase != 3'd7; i++) tick();
    check("sto reach store", 32'(phase), 7);
    check("sto store ctl", 32'(ctl), 32'(SEL | WR | DE));
    #1;
    rst = 1'b0;
    #1;
    check("sto rst ctl", 32'(ctl), 0);
    check("sto rst phase", 32'(phase), 0);
    #3;
    rst = 1'b1;

`ifdef CPU_CTRL_SINGLE_STEP_EN
    bus.opcode = 3'd5;
    tick();
    for (int i = 0; i < 20 && !step_wait; i++) tick();
    check("ss wait", 32'(step_wait), 1);
    check("ss cnt1", 32'(instr_cnt), 1);
    repeat (10) tick();
    check("ss hold phase", 32'(phase), 0);
    check("ss hold ctl", 32'(ctl), 0);
    check("ss hold wait", 32'(step_wait), 1);
    step = 1'b1;
    repeat (30) tick();
    check("ss one instr cnt", 32'(instr_cnt), 2);
    check("ss rewait", 32'(step_wait), 1);
    check("ss rewait phase", 32'(phase), 0);
    step = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
